// File: rtl/jpeg_row_packer.sv
// Packs a 1-pixel/cycle raster stream into 8-pixel rows (a..h) tagged with a row index within the block.
// Optional JPEG_LEVEL_SHIFT_EN: pixels are stored MSB-inverted (level shifted to two's complement).
module jpeg_row_packer #(
    parameter int PIX_W = 8,
    parameter int ROWS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    output logic [PIX_W-1:0]         a,
    output logic [PIX_W-1:0]         b,
    output logic [PIX_W-1:0]         c,
    output logic [PIX_W-1:0]         d,
    output logic [PIX_W-1:0]         e,
    output logic [PIX_W-1:0]         f,
    output logic [PIX_W-1:0]         g,
    output logic [PIX_W-1:0]         h,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     row_last,
    output logic                     sof_err
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [2:0] LAST_COL = 3'd7;

    logic [2:0]       col_q, col_d;
    logic             asm_full_q, asm_full_d;
    logic             asm_sof_q, asm_sof_d;
    logic             row_valid_q, row_valid_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sof_err_q, sof_err_d;

    logic [PIX_W-1:0] asm_q [8];
    logic [PIX_W-1:0] out_q [8];
    logic [PIX_W-1:0] out_d [8];

    logic             accept;
    logic             out_free;
    logic             restart;
    logic             complete;
    logic             load_direct;
    logic             load_drain;
    logic             load;
    logic [2:0]       wr_col;
    logic [IDX_W-1:0] row_tag;
    logic [PIX_W-1:0] pix_st;

`ifdef JPEG_LEVEL_SHIFT_EN
    assign pix_st = {~pix_in[PIX_W-1], pix_in[PIX_W-2:0]};
`else
    assign pix_st = pix_in;
`endif

    assign accept      = pix_valid & ~asm_full_q;
    assign out_free    = ~row_valid_q | row_ready;
    // An sof in mid-row abandons the partial row and restarts at slot 0.
    assign restart     = accept & pix_sof & (col_q != 3'd0);
    assign complete    = accept & ~restart & (col_q == LAST_COL);
    assign load_direct = complete & out_free;
    assign load_drain  = asm_full_q & out_free;
    assign load        = load_direct | load_drain;
    assign wr_col      = pix_sof ? 3'd0 : col_q;
    assign row_tag     = asm_sof_q ? '0 : cnt_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        col_d       = col_q;
        asm_full_d  = asm_full_q;
        asm_sof_d   = asm_sof_q;
        row_valid_d = row_valid_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        sof_err_d   = sof_err_q;
        for (int i = 0; i < 8; i++) out_d[i] = out_q[i];

        if (accept) begin
            col_d = pix_sof ? 3'd1 : col_q + 3'd1;
            if (pix_sof || col_q == 3'd0) asm_sof_d = pix_sof;
        end

        if (restart) sof_err_d = 1'b1;

        if (complete && !out_free) asm_full_d = 1'b1;
        else if (load_drain)       asm_full_d = 1'b0;

        // The eighth pixel bypasses the assembly register when the output slot can take it.
        if (load_direct) begin
            for (int i = 0; i < 7; i++) out_d[i] = asm_q[i];
            out_d[7] = pix_st;
        end else if (load_drain) begin
            for (int i = 0; i < 8; i++) out_d[i] = asm_q[i];
        end

        if (load) begin
            row_valid_d = 1'b1;
            row_idx_d   = row_tag;
            cnt_d       = row_tag + IDX_W'(1);
        end else if (row_ready) begin
            row_valid_d = 1'b0;
        end
    end

    // NOTE: the assembly buffer is pure datapath guarded by col/asm_full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) asm_q[wr_col] <= pix_st;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            asm_full_q  <= 1'b0;
            asm_sof_q   <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            cnt_q       <= '0;
            sof_err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) out_q[i] <= '0;
        end else begin
            col_q       <= col_d;
            asm_full_q  <= asm_full_d;
            asm_sof_q   <= asm_sof_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            sof_err_q   <= sof_err_d;
            for (int i = 0; i < 8; i++) out_q[i] <= out_d[i];
        end
    end

    assign pix_ready = ~asm_full_q;
    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_last  = (row_idx_q == IDX_W'(ROWS - 1));
    assign sof_err   = sof_err_q;
    assign a = out_q[0];
    assign b = out_q[1];
    assign c = out_q[2];
    assign d = out_q[3];
    assign e = out_q[4];
    assign f = out_q[5];
    assign g = out_q[6];
    assign h = out_q[7];

endmodule
